// File: rtl/pnml_racetrack_lim.sv
// pNML racetrack track with logic-in-memory ops, bidirectional shifting and a
// saturating count of conditional domain-switching events.
module pnml_racetrack_lim #(
    parameter int N_CELLS = 32,
    parameter int CNT_W   = 16,
    parameter int SH_W    = $clog2(N_CELLS + 1)
) (
    input  logic               clk_i,
    input  logic               rstn,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [3:0]         cmd_op_i,
    input  logic [N_CELLS-1:0] cmd_operand_i,
    input  logic [SH_W-1:0]    cmd_shamt_i,
    input  logic               fill_i,
    output logic               rsp_valid_o,
    output logic [N_CELLS-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               shift_out_o,
    output logic [CNT_W-1:0]   flips_o,
    output logic [N_CELLS-1:0] track_o
);
    localparam logic [3:0] OP_WRITE  = 4'd1;
    localparam logic [3:0] OP_NAND   = 4'd3;
    localparam logic [3:0] OP_NOR    = 4'd4;
    localparam logic [3:0] OP_AND    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_SFWD   = 4'd7;
    localparam logic [3:0] OP_SBWD   = 4'd8;
    localparam logic [3:0] OP_CLRCNT = 4'd9;

    localparam int SUM_W = ((CNT_W > SH_W) ? CNT_W : SH_W) + 1;
    localparam logic [SH_W-1:0]  SH_MAX  = SH_W'(N_CELLS);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [2:0] {IDLE, EXEC, INV, SHIFT, RESP} state_t;

    state_t             state_reg;
    logic [3:0]         op_reg;
    logic [N_CELLS-1:0] operand_reg;
    logic [SH_W-1:0]    remaining_reg;
    logic [N_CELLS-1:0] track_reg;
    logic [N_CELLS-1:0] track_next;
    logic [SH_W-1:0]    shamt_clamped;
    logic               start_shift;
    logic               clr_cnt;
    logic [SH_W-1:0]    pop;
    logic [SUM_W-1:0]   flips_sum;
    logic [CNT_W-1:0]   flips_next;

    function automatic logic [SH_W-1:0] popcount(input logic [N_CELLS-1:0] v);
        logic [SH_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CELLS; i++) c = c + SH_W'(v[i]);
        return c;
    endfunction

    assign cmd_ready_o   = (state_reg == IDLE);
    assign track_o       = track_reg;
    assign shamt_clamped = (cmd_shamt_i > SH_MAX) ? SH_MAX : cmd_shamt_i;
    assign start_shift   = ((cmd_op_i == OP_SFWD) || (cmd_op_i == OP_SBWD)) && (shamt_clamped != '0);
    assign clr_cnt       = (state_reg == EXEC) && (op_reg == OP_CLRCNT);

    // Non-updating states leave track_next == track_reg, so they contribute no flips.
    always_comb begin
        track_next = track_reg;
        case (state_reg)
            EXEC: begin
                case (op_reg)
                    OP_WRITE:        track_next = operand_reg;
                    OP_NAND, OP_AND: track_next = ~(track_reg & operand_reg);
                    OP_NOR, OP_OR:   track_next = ~(track_reg | operand_reg);
                    default:         track_next = track_reg;
                endcase
            end
            INV:   track_next = ~track_reg;
            SHIFT: track_next = (op_reg == OP_SFWD) ? {track_reg[N_CELLS-2:0], fill_i}
                                                    : {fill_i, track_reg[N_CELLS-1:1]};
            default: track_next = track_reg;
        endcase
    end

    assign pop        = popcount(track_reg ^ track_next);
    assign flips_sum  = SUM_W'(flips_o) + SUM_W'(pop);
    assign flips_next = (flips_sum > CNT_MAX) ? {CNT_W{1'b1}} : flips_sum[CNT_W-1:0];

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            operand_reg   <= '0;
            remaining_reg <= '0;
            track_reg     <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_err_o     <= 1'b0;
            shift_out_o   <= 1'b0;
            flips_o       <= '0;
        end else begin
            track_reg <= track_next;
            flips_o   <= clr_cnt ? '0 : flips_next;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_reg        <= cmd_op_i;
                        operand_reg   <= cmd_operand_i;
                        remaining_reg <= shamt_clamped;
                        state_reg     <= start_shift ? SHIFT : EXEC;
                    end
                end
                EXEC: begin
                    if ((op_reg == OP_AND) || (op_reg == OP_OR)) begin
                        state_reg <= INV;
                    end else begin
                        state_reg   <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= track_next;
                        rsp_err_o   <= (op_reg > OP_CLRCNT);
                    end
                end
                INV: begin
                    state_reg   <= RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_data_o  <= track_next;
                    rsp_err_o   <= 1'b0;
                end
                SHIFT: begin
                    shift_out_o   <= (op_reg == OP_SFWD) ? track_reg[N_CELLS-1] : track_reg[0];
                    remaining_reg <= remaining_reg - SH_W'(1);
                    if (remaining_reg == SH_W'(1)) begin
                        state_reg   <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= track_next;
                        rsp_err_o   <= 1'b0;
                    end
                end
                RESP: begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pnml_racetrack_lim.sv
// Directed plus randomized commands against a per-command behavioural model;
// a second instance with a 4-bit counter exercises saturation.
module tb_pnml_racetrack_lim;
    localparam int N = 32;
    localparam int SH_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn, cmd_valid, fill;
    logic [3:0]      cmd_op;
    logic [N-1:0]    cmd_operand;
    logic [SH_W-1:0] cmd_shamt;
    logic            cmd_ready, rsp_valid, rsp_err, shift_out;
    logic [N-1:0]    rsp_data, track;
    logic [15:0]     flips;
    logic            s_ready, s_rsp_valid, s_rsp_err, s_shift_out;
    logic [N-1:0]    s_rsp_data, s_track;
    logic [3:0]      s_flips;

    pnml_racetrack_lim #(.N_CELLS(N), .CNT_W(16)) u_dut (
        .clk_i(clk), .rstn(rstn), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_operand_i(cmd_operand), .cmd_shamt_i(cmd_shamt),
        .fill_i(fill), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .shift_out_o(shift_out), .flips_o(flips), .track_o(track)
    );

    pnml_racetrack_lim #(.N_CELLS(N), .CNT_W(4)) u_sat (
        .clk_i(clk), .rstn(rstn), .cmd_valid_i(cmd_valid), .cmd_ready_o(s_ready),
        .cmd_op_i(cmd_op), .cmd_operand_i(cmd_operand), .cmd_shamt_i(cmd_shamt),
        .fill_i(fill), .rsp_valid_o(s_rsp_valid), .rsp_data_o(s_rsp_data), .rsp_err_o(s_rsp_err),
        .shift_out_o(s_shift_out), .flips_o(s_flips), .track_o(s_track)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0] m_track;
    int           m_flips, m_flips4;
    logic         m_shout;

    logic [N-1:0] last_data;
    int           last_flips, last_lat;
    logic         last_err, last_shout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_track = '0; m_flips = 0; m_flips4 = 0; m_shout = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [N-1:0] b, input logic [SH_W-1:0] sh,
                           input logic f, input bit hold);
        logic [N-1:0] t, mid, nt;
        int s, flipsum, e_lat, n;
        bit e_err, got;
        t = m_track; flipsum = 0; e_err = 0; e_lat = 2;
        s = (int'(sh) > N) ? N : int'(sh);
        case (op)
            4'd1: begin flipsum = $countones(t ^ b); t = b; end
            4'd3: begin mid = ~(t & b); flipsum = $countones(t ^ mid); t = mid; end
            4'd4: begin mid = ~(t | b); flipsum = $countones(t ^ mid); t = mid; end
            4'd5: begin mid = ~(t & b); flipsum = $countones(t ^ mid) + $countones(mid ^ ~mid);
                        t = t & b; e_lat = 3; end
            4'd6: begin mid = ~(t | b); flipsum = $countones(t ^ mid) + $countones(mid ^ ~mid);
                        t = t | b; e_lat = 3; end
            4'd7, 4'd8: begin
                if (s > 0) e_lat = s + 1;
                for (int k = 0; k < s; k++) begin
                    if (op == 4'd7) begin m_shout = t[N-1]; nt = {t[N-2:0], f}; end
                    else            begin m_shout = t[0];   nt = {f, t[N-1:1]}; end
                    flipsum += $countones(t ^ nt);
                    t = nt;
                end
            end
            4'd0, 4'd2, 4'd9: ;
            default: e_err = 1;
        endcase
        if (op == 4'd9) begin
            m_flips = 0; m_flips4 = 0;
        end else begin
            m_flips  = (m_flips + flipsum > 65535) ? 65535 : m_flips + flipsum;
            m_flips4 = (m_flips4 + flipsum > 15) ? 15 : m_flips4 + flipsum;
        end
        m_track = t;

        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_operand = b; cmd_shamt = sh; fill = f;
        @(posedge clk);
        n = 1; got = 0;
        while (!got && n <= 80) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
            end else begin
                if (hold) begin
                    cmd_op = 4'd1; cmd_operand = $urandom;
                    chk("busy_ready", cmd_ready, 0);
                end else begin
                    cmd_valid = 1'b0;
                end
                @(posedge clk);
                n++;
            end
        end
        cmd_valid = 1'b0;
        chk("rsp_seen", got, 1);
        chk("latency", n, e_lat);
        chk("rsp_data", rsp_data, m_track);
        chk("rsp_err", rsp_err, e_err);
        chk("flips", flips, m_flips);
        chk("flips4", s_flips, m_flips4);
        chk("track", track, m_track);
        chk("shift_out", shift_out, m_shout);
        chk("resp_ready", cmd_ready, 0);
        chk("sat_view", {s_ready, s_rsp_valid, s_rsp_err, s_shift_out, s_track, s_rsp_data},
            {1'b0, 1'b1, e_err, m_shout, m_track, m_track});
        last_data = rsp_data; last_flips = flips; last_lat = n; last_err = rsp_err;
        last_shout = shift_out;
        $display("txn op=%0d b=%h sh=%0d fill=%0d hold=%0d -> data=%h err=%0d lat=%0d flips=%0d flips4=%0d",
                 op, b, sh, f, hold, rsp_data, rsp_err, n, flips, s_flips);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_operand = '0; cmd_shamt = '0; fill = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", {cmd_ready, rsp_valid, rsp_err, shift_out, flips, track, rsp_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0});
        rstn = 1'b1;
        @(negedge clk);

        // NAND after WRITE: 16 flips for the write, 24 for the NAND
        run_cmd(4'd1, 32'hF0F0_F0F0, 6'd0, 1'b0, 0);
        run_cmd(4'd3, 32'hFF00_FF00, 6'd0, 1'b0, 0);
        chk("nand_data", last_data, 32'h0FFF_0FFF);
        chk("nand_lat", last_lat, 2);
        chk("nand_flips", last_flips, 40);

        run_cmd(4'd1, 32'hA5A5_A5A5, 6'd0, 1'b0, 0);
        run_cmd(4'd5, 32'h0F0F_0F0F, 6'd0, 1'b0, 0);
        chk("and_data", last_data, 32'h0505_0505);
        chk("and_lat", last_lat, 3);
        run_cmd(4'd6, 32'hF000_0000, 6'd0, 1'b0, 0);
        chk("or_data", last_data, 32'hF505_0505);

        run_cmd(4'd1, 32'h8000_0001, 6'd0, 1'b0, 0);
        run_cmd(4'd7, 32'h0, 6'd1, 1'b0, 0);
        chk("sfwd_data", last_data, 32'h0000_0002);
        chk("sfwd_out", last_shout, 1);
        run_cmd(4'd8, 32'h0, 6'd40, 1'b1, 0);
        chk("sbwd_data", last_data, 32'hFFFF_FFFF);
        chk("sbwd_lat", last_lat, 33);

        run_cmd(4'd12, 32'h1234_5678, 6'd0, 1'b0, 0);
        chk("illegal_err", last_err, 1);
        chk("illegal_data", last_data, 32'hFFFF_FFFF);
        run_cmd(4'd7, 32'h0, 6'd10, 1'b0, 1);
        run_cmd(4'd2, 32'h0, 6'd0, 1'b0, 0);
        chk("hold_no_accept", last_data, 32'hFFFF_FC00);

        // Asynchronous reset in the middle of a 20-position shift
        run_cmd(4'd1, 32'h1357_9BDF, 6'd0, 1'b0, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd7; cmd_shamt = 6'd20; fill = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rstn = 1'b0;
        model_reset();
        #1 chk("midrst_state", {track, flips, s_flips, rsp_valid, cmd_ready}, {32'd0, 16'd0, 4'd0, 1'b0, 1'b1});
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_quiet", {rsp_valid, cmd_ready, track}, {1'b0, 1'b1, 32'd0});
        end

        run_cmd(4'd1, 32'hFFFF_FFFF, 6'd0, 1'b0, 0);
        run_cmd(4'd1, 32'h0000_0000, 6'd0, 1'b0, 0);
        chk("sat_flips4", s_flips, 15);
        run_cmd(4'd9, 32'h0, 6'd0, 1'b0, 0);
        chk("clrcnt_flips4", s_flips, 0);
        chk("clrcnt_flips", flips, 0);

        for (int i = 0; i < 150; i++) begin
            run_cmd(4'($urandom_range(0, 15)), $urandom, 6'($urandom_range(0, 40)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
